// File: rtl/nios2_debug_cmd_sysclk_if.sv
// Bundle for the debug command path: TCK-side toggles/snapshots in, command FIFO head,
// action pulses and status out. The design attaches to the slave modport.
interface nios2_debug_cmd_sysclk_if #(
    parameter int DATA_W     = 38,
    parameter int IR_W       = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int CH = 1 << IR_W;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              ir_tgl;
    logic              upd_tgl;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              cmd_ready;
    logic              clr_ovf;
    logic              cmd_valid;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] cmd_data;
    logic [CH-1:0]     act_pulse;
    logic [CH-1:0]     noact_pulse;
    logic [LW-1:0]     level;
    logic              ovf;

    modport slave (
        input  ir_tgl, upd_tgl, ir_in, sr, cmd_ready, clr_ovf,
        output cmd_valid, cmd_ir, cmd_data, act_pulse, noact_pulse, level, ovf
    );

    modport master (
        output ir_tgl, upd_tgl, ir_in, sr, cmd_ready, clr_ovf,
        input  cmd_valid, cmd_ir, cmd_data, act_pulse, noact_pulse, level, ovf
    );
endinterface

// File: rtl/nios2_debug_cmd_sysclk.sv
// System-clock side of the Nios II debug command path: synchronises TCK toggles,
// queues {channel, payload} commands in a FWFT FIFO and issues per-channel pulses on pop.
module nios2_debug_cmd_sysclk #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                     clk,
    input logic                     reset,
    nios2_debug_cmd_sysclk_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CH = 1 << IR_W;
    localparam int EW = IR_W + DATA_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] ir_sync_r;
    logic [SYNC_STAGES-1:0] upd_sync_r;
    logic                   ir_hist_r;
    logic                   upd_hist_r;
    logic                   ir_edge_s;
    logic                   upd_edge_s;
    logic [IR_W-1:0]        ir_reg_r;
    logic [IR_W-1:0]        ir_sel_s;
    logic [EW-1:0]          mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [LW-1:0]          level_r;
    logic                   ovf_r;
    logic                   valid_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   wr_en_s;
    logic                   drop_s;
    logic [EW-1:0]          head_s;
    logic [IR_W-1:0]        head_ir_s;
    logic [DATA_W-1:0]      head_data_s;
    logic [CH-1:0]          act_s;
    logic [CH-1:0]          noact_s;

    // Toggle synchronisers followed by one history flop each
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_sync_r  <= {SYNC_STAGES{1'b0}};
            upd_sync_r <= {SYNC_STAGES{1'b0}};
            ir_hist_r  <= 1'b0;
            upd_hist_r <= 1'b0;
        end else begin
            ir_sync_r  <= {ir_sync_r[SYNC_STAGES-2:0], bus.ir_tgl};
            upd_sync_r <= {upd_sync_r[SYNC_STAGES-2:0], bus.upd_tgl};
            ir_hist_r  <= ir_sync_r[SYNC_STAGES-1];
            upd_hist_r <= upd_sync_r[SYNC_STAGES-1];
        end
    end

    assign ir_edge_s  = ir_sync_r[SYNC_STAGES-1] ^ ir_hist_r;
    assign upd_edge_s = upd_sync_r[SYNC_STAGES-1] ^ upd_hist_r;

    // Instruction register, updated once per update-IR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg_r <= {IR_W{1'b0}};
        end else if (ir_edge_s) begin
            ir_reg_r <= bus.ir_in;
        end else begin
            ir_reg_r <= ir_reg_r;
        end
    end

    // A coincident update-IR must tag the command with the new instruction
    always_comb begin
        ir_sel_s = ir_reg_r;
        if (ir_edge_s) begin
            ir_sel_s = bus.ir_in;
        end else begin
            ir_sel_s = ir_reg_r;
        end
    end

    // FIFO handshake: a pop frees the slot a same-cycle push needs when full
    always_comb begin
        valid_s = (level_r != {LW{1'b0}});
        full_s  = (level_r == FULL_LVL);
        pop_s   = valid_s & bus.cmd_ready;
        wr_en_s = upd_edge_s & (~full_s | pop_s);
        drop_s  = upd_edge_s & full_s & ~pop_s;
    end

    // Command storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {ir_sel_s, bus.sr};
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow; a dropping push outranks the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign head_ir_s   = head_s[EW-1:DATA_W];
    assign head_data_s = head_s[DATA_W-1:0];

    // Payload MSB chooses between "take action" and "take no action" on the head channel
    always_comb begin
        act_s   = {CH{1'b0}};
        noact_s = {CH{1'b0}};
        if (pop_s) begin
            if (head_data_s[DATA_W-1]) begin
                act_s[head_ir_s] = 1'b1;
            end else begin
                noact_s[head_ir_s] = 1'b1;
            end
        end else begin
            act_s   = {CH{1'b0}};
            noact_s = {CH{1'b0}};
        end
    end

    assign bus.cmd_valid   = valid_s;
    assign bus.cmd_ir      = head_ir_s;
    assign bus.cmd_data    = head_data_s;
    assign bus.act_pulse   = act_s;
    assign bus.noact_pulse = noact_s;
    assign bus.level       = level_r;
    assign bus.ovf         = ovf_r;
endmodule

// File: tb/tb_nios2_debug_cmd_sysclk.sv
// Bench for nios2_debug_cmd_sysclk: table-driven single commands, hand-written FIFO
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_nios2_debug_cmd_sysclk;
    localparam int DATA_W      = 38;
    localparam int IR_W        = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CH          = 1 << IR_W;

    typedef logic [IR_W+DATA_W-1:0] ent_t;

    typedef struct {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
        logic              same;
        logic [IR_W-1:0]   exp_ir;
        logic [CH-1:0]     exp_act;
        logic [CH-1:0]     exp_noact;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nios2_debug_cmd_sysclk_if #(.DATA_W(DATA_W), .IR_W(IR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    nios2_debug_cmd_sysclk #(
        .DATA_W(DATA_W), .IR_W(IR_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of commands plus edge-numbered pending toggle events
    ent_t            mq[$];
    int unsigned     ir_due[$];
    int unsigned     upd_due[$];
    int unsigned     ecount = 0;
    logic            last_ir;
    logic            last_upd;
    logic            m_ovf;
    logic [IR_W-1:0] m_ir_reg;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        ir_due.delete();
        upd_due.delete();
        last_ir  = 1'b0;
        last_upd = 1'b0;
        m_ovf    = 1'b0;
        m_ir_reg = '0;
    endtask

    // A toggle first seen at edge N becomes an edge event that acts at edge N+SYNC_STAGES
    task automatic model_edge();
        logic ir_now, upd_now, pop, was_full, drop;
        logic [IR_W-1:0] sel;
        ecount++;
        ir_now  = (ir_due.size() != 0) && (ir_due[0] == ecount);
        upd_now = (upd_due.size() != 0) && (upd_due[0] == ecount);
        if (ir_now) void'(ir_due.pop_front());
        if (upd_now) void'(upd_due.pop_front());
        pop      = (mq.size() != 0) && bus.cmd_ready;
        was_full = (mq.size() == FIFO_DEPTH);
        sel      = ir_now ? bus.ir_in : m_ir_reg;
        drop     = upd_now && was_full && !pop;
        if (pop) void'(mq.pop_front());
        if (upd_now && !drop) mq.push_back({sel, bus.sr});
        if (drop) m_ovf = 1'b1;
        else if (bus.clr_ovf) m_ovf = 1'b0;
        if (ir_now) m_ir_reg = bus.ir_in;
        if (bus.ir_tgl !== last_ir) begin
            ir_due.push_back(ecount + SYNC_STAGES);
            last_ir = bus.ir_tgl;
        end
        if (bus.upd_tgl !== last_upd) begin
            upd_due.push_back(ecount + SYNC_STAGES);
            last_upd = bus.upd_tgl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        logic [CH-1:0] e_act, e_noact;
        ent_t head;
        e_act   = '0;
        e_noact = '0;
        chk("m_valid", bus.cmd_valid, mq.size() != 0);
        chk("m_level", bus.level, mq.size());
        chk("m_ovf", bus.ovf, m_ovf);
        if (mq.size() != 0) begin
            head = mq[0];
            chk("m_cmd_ir", bus.cmd_ir, head[IR_W+DATA_W-1:DATA_W]);
            chk("m_cmd_data", bus.cmd_data, head[DATA_W-1:0]);
            if (bus.cmd_ready) begin
                if (head[DATA_W-1]) e_act[head[IR_W+DATA_W-1:DATA_W]] = 1'b1;
                else e_noact[head[IR_W+DATA_W-1:DATA_W]] = 1'b1;
            end
        end
        chk("m_act", bus.act_pulse, e_act);
        chk("m_noact", bus.noact_pulse, e_noact);
    endtask

    // Tag with ir_in by toggling both lines together, then wait until the push lands
    task automatic push_cmd(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] data);
        bus.ir_in   = ir;
        bus.sr      = data;
        bus.ir_tgl  = ~bus.ir_tgl;
        bus.upd_tgl = ~bus.upd_tgl;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    function automatic logic [CH-1:0] chan_bit(input logic [IR_W-1:0] ir);
        logic [CH-1:0] one;
        one = 4'b0001;
        return one << ir;
    endfunction

    vec_t              vecs[5];
    logic [DATA_W-1:0] pay[5];
    logic [IR_W-1:0]   pay_ir[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{2'd2, 38'h20_0000_0ABC, 1'b0, 2'd2, 4'b0100, 4'b0000};
        vecs[1] = '{2'd1, 38'h00_1234_5678, 1'b0, 2'd1, 4'b0000, 4'b0010};
        vecs[2] = '{2'd3, 38'h3F_FFFF_FFFF, 1'b1, 2'd3, 4'b1000, 4'b0000};
        vecs[3] = '{2'd2, 38'h1F_0000_0001, 1'b0, 2'd2, 4'b0000, 4'b0100};
        vecs[4] = '{2'd0, 38'h2A_AAAA_AAAA, 1'b1, 2'd0, 4'b0001, 4'b0000};
        pay[0] = 38'h20_0000_0001; pay_ir[0] = 2'd0;
        pay[1] = 38'h00_0000_0002; pay_ir[1] = 2'd1;
        pay[2] = 38'h3F_0000_0003; pay_ir[2] = 2'd2;
        pay[3] = 38'h01_0000_0004; pay_ir[3] = 2'd3;
        pay[4] = 38'h2F_0000_0005; pay_ir[4] = 2'd1;

        reset         = 1'b1;
        bus.ir_tgl    = 1'b0;
        bus.upd_tgl   = 1'b0;
        bus.ir_in     = '0;
        bus.sr        = '0;
        bus.cmd_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        model_reset();
        repeat (2) tick();
        chk("rst_valid", bus.cmd_valid, 1'b0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_act", bus.act_pulse, 0);
        chk("rst_noact", bus.noact_pulse, 0);
        reset = 1'b0;

        // Single commands: latency, tagging, payload and pulse polarity
        for (int v = 0; v < 5; v++) begin
            bus.cmd_ready = 1'b0;
            bus.ir_in     = vecs[v].ir;
            bus.sr        = vecs[v].data;
            if (!vecs[v].same) begin
                bus.ir_tgl = ~bus.ir_tgl;
                repeat (4) tick();
            end
            bus.upd_tgl = ~bus.upd_tgl;
            if (vecs[v].same) bus.ir_tgl = ~bus.ir_tgl;
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (bus.cmd_valid) begin
                    lat = k;
                    break;
                end
            end
            chk("vec_latency", lat, SYNC_STAGES + 1);
            chk("vec_cmd_ir", bus.cmd_ir, vecs[v].exp_ir);
            chk("vec_cmd_data", bus.cmd_data, vecs[v].data);
            chk("vec_hold_act", bus.act_pulse, 0);
            chk("vec_hold_noact", bus.noact_pulse, 0);
            bus.cmd_ready = 1'b1;
            #1;
            chk("vec_act", bus.act_pulse, vecs[v].exp_act);
            chk("vec_noact", bus.noact_pulse, vecs[v].exp_noact);
            tick();
            bus.cmd_ready = 1'b0;
            #1;
            chk("vec_after_act", bus.act_pulse, 0);
            chk("vec_after_level", bus.level, 0);
        end

        // Overflow: five pushes into a depth-4 FIFO, then ordered drain and clear
        for (int i = 0; i < 5; i++) push_cmd(pay_ir[i], pay[i]);
        chk("ovf_level", bus.level, FIFO_DEPTH);
        chk("ovf_set", bus.ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.cmd_ready = 1'b1;
            #1;
            chk("ovf_pop_data", bus.cmd_data, pay[i]);
            chk("ovf_pop_ir", bus.cmd_ir, pay_ir[i]);
            chk("ovf_pop_act", bus.act_pulse, pay[i][DATA_W-1] ? chan_bit(pay_ir[i]) : 4'b0000);
            chk("ovf_pop_noact", bus.noact_pulse, pay[i][DATA_W-1] ? 4'b0000 : chan_bit(pay_ir[i]));
            tick();
        end
        bus.cmd_ready = 1'b0;
        #1;
        chk("ovf_drained", bus.level, 0);
        chk("ovf_sticky", bus.ovf, 1'b1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        #1;
        chk("ovf_cleared", bus.ovf, 1'b0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) push_cmd(pay_ir[i], pay[i]);
        bus.ir_in   = pay_ir[4];
        bus.sr      = pay[4];
        bus.ir_tgl  = ~bus.ir_tgl;
        bus.upd_tgl = ~bus.upd_tgl;
        repeat (SYNC_STAGES) tick();
        bus.cmd_ready = 1'b1;
        #1;
        chk("pp_level_before", bus.level, FIFO_DEPTH);
        tick();
        bus.cmd_ready = 1'b0;
        #1;
        chk("pp_level_after", bus.level, FIFO_DEPTH);
        chk("pp_no_ovf", bus.ovf, 1'b0);
        for (int i = 1; i < 5; i++) begin
            bus.cmd_ready = 1'b1;
            #1;
            chk("pp_order", bus.cmd_data, pay[i]);
            tick();
        end
        bus.cmd_ready = 1'b0;

        // Reset with three commands pending
        for (int i = 0; i < 3; i++) push_cmd(pay_ir[i], pay[i]);
        chk("rst3_level_pre", bus.level, 3);
        reset = 1'b1;
        #1;
        chk("rst3_valid", bus.cmd_valid, 1'b0);
        chk("rst3_level", bus.level, 0);
        bus.ir_tgl  = 1'b0;
        bus.upd_tgl = 1'b0;
        model_reset();
        repeat (2) tick();
        reset         = 1'b0;
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst3_no_act", bus.act_pulse, 0);
            chk("rst3_no_noact", bus.noact_pulse, 0);
            chk("rst3_empty", bus.cmd_valid, 1'b0);
        end

        // Randomized traffic against the reference model, including back-to-back pushes
        for (int c = 0; c < 600; c++) begin
            if (c == 350) begin
                reset       = 1'b1;
                bus.ir_tgl  = 1'b0;
                bus.upd_tgl = 1'b0;
                model_reset();
                tick();
                reset = 1'b0;
            end
            bus.cmd_ready = ($urandom_range(0, 99) < ((c < 300) ? 25 : 70));
            bus.clr_ovf   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.ir_in  = IR_W'($urandom_range(0, CH - 1));
                bus.ir_tgl = ~bus.ir_tgl;
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.sr      = DATA_W'({$urandom, $urandom});
                bus.upd_tgl = ~bus.upd_tgl;
            end
            #1;
            check_model();
            tick();
        end
        bus.clr_ovf   = 1'b0;
        bus.cmd_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nios2_debug_cmd_sysclk.md
NIOS2_DEBUG_CMD_SYSCLK -- requirements
Module: nios2_debug_cmd_sysclk

Interface
REQ-001 SHALL have parameter DATA_W, default 38, which sets the width of the debug shift-register snapshot and the command payload.
REQ-002 SHALL have parameter IR_W, default 2, which sets the width of the instruction register and selects among 2**IR_W command channels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, which sets the number of pending-command FIFO entries; it is a power of 2 and at least 2.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, which sets the number of synchroniser flops per toggle input; it is at least 2.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  system clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 ir_tgl  in  1  TCK-domain level; it toggles once per update-IR.
REQ-009 upd_tgl  in  1  TCK-domain level; it toggles once per update-DR.
REQ-010 ir_in  in  IR_W  instruction value; it is quasi-static around an ir_tgl change.
REQ-011 sr  in  DATA_W  shift-register snapshot; it is held stable by TCK logic until the next upd_tgl change has been consumed.
REQ-012 cmd_ready  in  1  consumer accepts the head command.
REQ-013 clr_ovf  in  1  synchronous clear of ovf.
REQ-014 cmd_valid  out  1  FIFO not empty.
REQ-015 cmd_ir  out  IR_W  head command channel.
REQ-016 cmd_data  out  DATA_W  head command payload; it is the jdo equivalent.
REQ-017 act_pulse  out  2**IR_W  one-hot single-cycle pulse meaning "take action" on channel cmd_ir.
REQ-018 noact_pulse  out  2**IR_W  one-hot single-cycle pulse meaning "take no action" on channel cmd_ir.
REQ-019 level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-020 ovf  out  1  sticky flag indicating a command was dropped.

Function
REQ-021 SHALL pass each toggle input through SYNC_STAGES flops followed by one history flop; an edge is asserted when the last synchroniser stage differs from the history flop.
REQ-022 On an ir edge, SHALL latch ir_in into ir_reg.
REQ-023 On an upd edge, SHALL push {ir_sel, sr} into the FIFO; ir_sel is ir_in if an ir edge occurs in the same cycle, otherwise ir_reg.
REQ-024 SHALL make latency fixed: cmd_valid rises after the (SYNC_STAGES+1)th rising clk edge, counting the edge that first samples the new upd_tgl level, provided the FIFO was empty.
REQ-025 FIFO SHALL be first-word-fall-through: cmd_ir and cmd_data show the head entry whenever cmd_valid=1, and are don't-care otherwise.
REQ-026 SHALL pop on cmd_valid&&cmd_ready, and in that same cycle assert act_pulse[cmd_ir] if cmd_data[DATA_W-1]=1, else noact_pulse[cmd_ir]; pulses are combinational from the head and high for exactly that cycle.
REQ-027 With cmd_ready=0, SHALL hold the head and keep act_pulse and noact_pulse at 0.
REQ-028 Push while full without a pop SHALL drop the new command, leave FIFO contents unchanged, and set ovf=1.
REQ-029 Push and pop in the same cycle SHALL both take effect, including when full (no ovf) and when holding one entry; level is unchanged.
REQ-030 Pop while empty SHALL be impossible (cmd_valid=0) and have no effect.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be write count minus read count, in the range 0..FIFO_DEPTH.
REQ-032 ovf SHALL clear on clr_ovf=1; if clr_ovf and a dropping push coincide, set wins.
REQ-033 Two upd edges closer than one cycle are impossible by construction; consecutive-cycle upd edges SHALL each push.

Reset
REQ-034 reset=1 SHALL asynchronously clear synchronisers, history flops, ir_reg, pointers, level and ovf; outputs SHALL read cmd_valid=0, pulses=0, level=0, ovf=0.
REQ-035 Reset asserted mid-operation SHALL discard all pending commands; TCK-side toggles are 0 at reset release, so no spurious edge occurs.
REQ-036 SHALL restart operation on the first clk edge after reset deasserts.

Verification
REQ-037 Reset, then ir_in=2 with ir_tgl 0->1, then sr=38'h20_0000_0ABC with upd_tgl 0->1 -> cmd_valid high after 3 edges from sampling, cmd_ir=2, cmd_data=38'h20_0000_0ABC; with cmd_ready=1 -> act_pulse=4'b0100 for one cycle, then level=0.
REQ-038 Payload with MSB=0 on channel 1 -> noact_pulse=4'b0010 on pop, and act_pulse stays 0.
REQ-039 cmd_ready=0 with 5 upd edges (DEPTH=4) -> level=4, ovf=1, and the first 4 payloads pop in order; clr_ovf -> ovf=0.
REQ-040 Full FIFO with a push and pop in the same cycle -> level stays 4, ovf stays 0, and the new entry is last in order.
REQ-041 ir_tgl and upd_tgl toggle in the same cycle with ir_in=3 -> the pushed cmd_ir is 3.
REQ-042 reset pulse with 3 entries pending -> cmd_valid=0 and level=0 immediately, with no pulses afterwards.
